snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Game-level sequencer that consumes the per-pixel collision status and decides, once per frame,
//  whether the snake dies, grows or just moves. Accumulates sticky hit/apple flags during the scan,
//  evaluates them at frame end, and issues move/grow/respawn/restart pulses. Also owns the score
//  and the score-dependent movement rate. Sits between the collision checker and the snake/apple
//  position logic.
// PARAMETERS
//  SCORE_W      8  score width; score saturates at 2^SCORE_W-1
//  MOVE_PERIOD  8  frames per move at score 0 (2..255)
//  MIN_PERIOD   2  fastest frames per move (1..MOVE_PERIOD)
//  SPEED_SHIFT  2  period shrinks by 1 for every 2^SPEED_SHIFT points
// PORTS
//  clk            in   1        clock
//  reset          in   1        synchronous, active-high
//  frame_end      in   1        1-cycle pulse after last visible pixel of a frame
//  coll_state     in   2        collision status: 00 reset, 01 collision, 10 apple, 11 none
//  start          in   1        start/restart request (level, already synchronised)
//  running        out  1        1 while state==RUN
//  game_over      out  1        1 while state==OVER
//  move_tick      out  1        1-cycle pulse: advance snake one cell
//  grow           out  1        1-cycle pulse: lengthen snake by one segment
//  apple_respawn  out  1        1-cycle pulse: place a new apple
//  restart        out  1        1-cycle pulse: reinitialise snake/apple positions
//  score          out  SCORE_W  apples collected this game
// BEHAVIOUR
//  - States: IDLE=0, RUN=1, OVER=2. Reset -> IDLE; all outputs 0, score 0, frame_cnt 0, flags 0.
//    Reset mid-game takes priority over every other event in that cycle.
//  - IDLE/OVER: start=1 -> RUN next cycle; restart pulses that cycle; score, frame_cnt, hit_flag and
//    apple_flag cleared. start ignored in RUN. coll_state ignored outside RUN.
//  - RUN flag capture (every cycle): hit_flag |= (coll_state==01); apple_flag |= (coll_state==10).
//    coll_state 00 and 11 leave flags unchanged.
//  - On frame_end in RUN, evaluate using hit_eff = hit_flag|(coll_state==01) and the same for apple,
//    so the frame_end cycle's status counts toward the closing frame. Then clear both flags.
//    * hit_eff=1 -> OVER; no grow/respawn/move_tick; hit wins over simultaneous apple.
//    * else apple_eff=1 -> grow=1, apple_respawn=1, score+1 (saturating, no wrap).
//    * Unless dying: frame_cnt+1; if frame_cnt+1 >= period -> move_tick=1, frame_cnt=0.
//      Apple and move_tick may pulse together.
//  - period = max(MIN_PERIOD, MOVE_PERIOD - (score >> SPEED_SHIFT)), using score before update;
//    compute with 9-bit unsigned, clamp before subtract (no underflow). frame_cnt is 8 bits.
//  - All pulse outputs registered: asserted exactly the cycle after frame_end (latency 1), 1 cycle.
//  - running/game_over registered from state; they change the cycle after the deciding event.
//  - frame_end outside RUN: no effect. score holds its value in OVER until the next start.
// TESTING
//  1 reset 3 cycles, then idle 2 frames -> all outputs 0, running=0; start=1 -> restart 1 cycle, running=1.
//  2 RUN, coll_state=11 for 8 frames (defaults) -> exactly one move_tick, one cycle after 8th frame_end.
//  3 coll_state=10 mid-frame, then 11 -> at frame_end+1: grow=1, apple_respawn=1, score 0->1; flag cleared next frame.
//  4 coll_state 10 and 01 in same frame -> game_over=1, running=0, no grow, score unchanged; frame_end ignored after.
//  5 score forced to 24 via apples -> period=max(2,8-6)=2; score=255 + apple -> stays 255.
//  6 reset asserted in RUN coincident with frame_end and coll_state=01 -> IDLE, score 0, no pulses.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - per-frame snake game sequencer: collision flags, score and move rate
module snake_game_ctrl #(
    parameter int SCORE_W     = 8,
    parameter int MOVE_PERIOD = 8,
    parameter int MIN_PERIOD  = 2,
    parameter int SPEED_SHIFT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_frame_end,
    input  logic [1:0]         i_coll_state,
    input  logic               i_start,
    output logic               o_running,
    output logic               o_game_over,
    output logic               o_move_tick,
    output logic               o_grow,
    output logic               o_apple_respawn,
    output logic               o_restart,
    output logic [SCORE_W-1:0] o_score
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int CW = (SCORE_W + 1 > 9) ? SCORE_W + 1 : 9;
    localparam logic [CW-1:0]      C_MOVE    = CW'(MOVE_PERIOD);
    localparam logic [CW-1:0]      C_MIN     = CW'(MIN_PERIOD);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t             r_state;
    logic [7:0]         r_frame_cnt;
    logic               r_hit_flag;
    logic               r_apple_flag;

    logic               w_hit_eff;
    logic               w_apple_eff;
    logic [CW-1:0]      w_score_shr;
    logic [CW-1:0]      w_period;
    logic [CW-1:0]      w_cnt_next;
    logic               w_move;

    assign w_hit_eff   = r_hit_flag   | (i_coll_state == 2'b01);
    assign w_apple_eff = r_apple_flag | (i_coll_state == 2'b10);

    // Clamp before subtracting so a large score can never wrap the period.
    assign w_score_shr = CW'(o_score) >> SPEED_SHIFT;
    assign w_period    = (w_score_shr >= C_MOVE - C_MIN) ? C_MIN : (C_MOVE - w_score_shr);
    assign w_cnt_next  = CW'(r_frame_cnt) + CW'(1);
    assign w_move      = (w_cnt_next >= w_period);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_frame_cnt     <= 8'd0;
            r_hit_flag      <= 1'b0;
            r_apple_flag    <= 1'b0;
            o_running       <= 1'b0;
            o_game_over     <= 1'b0;
            o_move_tick     <= 1'b0;
            o_grow          <= 1'b0;
            o_apple_respawn <= 1'b0;
            o_restart       <= 1'b0;
            o_score         <= '0;
        end else begin
            o_move_tick     <= 1'b0;
            o_grow          <= 1'b0;
            o_apple_respawn <= 1'b0;
            o_restart       <= 1'b0;
            case (r_state)
                IDLE, OVER: begin
                    if (i_start) begin
                        r_state      <= RUN;
                        o_running    <= 1'b1;
                        o_game_over  <= 1'b0;
                        o_restart    <= 1'b1;
                        o_score      <= '0;
                        r_frame_cnt  <= 8'd0;
                        r_hit_flag   <= 1'b0;
                        r_apple_flag <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_frame_end) begin
                        r_hit_flag   <= 1'b0;
                        r_apple_flag <= 1'b0;
                        if (w_hit_eff) begin
                            r_state     <= OVER;
                            o_running   <= 1'b0;
                            o_game_over <= 1'b1;
                        end else begin
                            if (w_apple_eff) begin
                                o_grow          <= 1'b1;
                                o_apple_respawn <= 1'b1;
                                if (o_score != SCORE_MAX) begin
                                    o_score <= o_score + SCORE_W'(1);
                                end
                            end
                            if (w_move) begin
                                o_move_tick <= 1'b1;
                                r_frame_cnt <= 8'd0;
                            end else begin
                                r_frame_cnt <= w_cnt_next[7:0];
                            end
                        end
                    end else begin
                        r_hit_flag   <= w_hit_eff;
                        r_apple_flag <= w_apple_eff;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    o_running   <= 1'b0;
                    o_game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed checks of the snake game sequencer
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_end;
    logic [1:0] coll_state;
    logic       start;
    logic       running;
    logic       game_over;
    logic       move_tick;
    logic       grow;
    logic       apple_respawn;
    logic       restart;
    logic [7:0] score;

    int n_vec = 0;
    int n_err = 0;

    snake_game_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .i_frame_end    (frame_end),
        .i_coll_state   (coll_state),
        .i_start        (start),
        .o_running      (running),
        .o_game_over    (game_over),
        .o_move_tick    (move_tick),
        .o_grow         (grow),
        .o_apple_respawn(apple_respawn),
        .o_restart      (restart),
        .o_score        (score)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two mid-frame cycles, then the frame_end cycle; returns just after the edge that registers the pulses.
    task automatic frame(input logic [1:0] mid, input logic [1:0] endc);
        coll_state = mid;
        tick();
        tick();
        coll_state = endc;
        frame_end  = 1'b1;
        tick();
        frame_end  = 1'b0;
        coll_state = 2'b11;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_end = 1'b0; coll_state = 2'b11; start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            frame(2'b01, 2'b10);
            n_vec++;
            if ({running, game_over, move_tick, grow, apple_respawn, restart, score} !== 14'd0) begin
                n_err++;
                $display("FAIL idle_outputs frame %0d: got %b want all zero", f,
                         {running, game_over, move_tick, grow, apple_respawn, restart, score});
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if ({restart, running, game_over} !== 3'b110) begin
            n_err++;
            $display("FAIL start_restart: restart/running/game_over=%b want 110", {restart, running, game_over});
        end
        tick();
        n_vec++;
        if ({restart, running} !== 2'b01) begin
            n_err++;
            $display("FAIL restart_one_cycle: restart/running=%b want 01", {restart, running});
        end
    endtask

    task automatic test_move_rate();
        int ticks = 0;
        for (int f = 1; f <= 8; f++) begin
            frame(2'b11, 2'b11);
            if (move_tick) ticks++;
            if (f == 8) begin
                n_vec++;
                if (move_tick !== 1'b1) begin
                    n_err++;
                    $display("FAIL move_tick_frame8: got %b want 1", move_tick);
                end
            end
        end
        n_vec++;
        if (ticks != 1) begin
            n_err++;
            $display("FAIL move_tick_count: got %0d want 1", ticks);
        end
        tick();
        n_vec++;
        if (move_tick !== 1'b0) begin
            n_err++;
            $display("FAIL move_tick_width: got %b want 0", move_tick);
        end
    endtask

    task automatic test_apple();
        frame(2'b10, 2'b11);
        n_vec++;
        if ({grow, apple_respawn, move_tick, score} !== {3'b110, 8'd1}) begin
            n_err++;
            $display("FAIL apple_pulse: grow/resp/tick=%b score=%0d want 110 score=1",
                     {grow, apple_respawn, move_tick}, score);
        end
        frame(2'b11, 2'b11);
        n_vec++;
        if ({grow, apple_respawn, score} !== {2'b00, 8'd1}) begin
            n_err++;
            $display("FAIL apple_flag_clear: grow/resp=%b score=%0d want 00 score=1",
                     {grow, apple_respawn}, score);
        end
    endtask

    task automatic test_hit_wins();
        coll_state = 2'b10;
        tick();
        coll_state = 2'b01;
        tick();
        frame(2'b11, 2'b11);
        n_vec++;
        if ({game_over, running, grow, apple_respawn, move_tick, score} !== {5'b10000, 8'd1}) begin
            n_err++;
            $display("FAIL hit_over: over/run/grow/resp/tick=%b score=%0d want 10000 score=1",
                     {game_over, running, grow, apple_respawn, move_tick}, score);
        end
        frame(2'b10, 2'b10);
        n_vec++;
        if ({game_over, running, grow, apple_respawn, move_tick, score} !== {5'b10000, 8'd1}) begin
            n_err++;
            $display("FAIL over_ignores_frame: over/run/grow/resp/tick=%b score=%0d want 10000 score=1",
                     {game_over, running, grow, apple_respawn, move_tick}, score);
        end
    endtask

    task automatic test_speedup_saturate();
        int ticks = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if ({restart, running, game_over, score} !== {3'b110, 8'd0}) begin
            n_err++;
            $display("FAIL restart_from_over: rst/run/over=%b score=%0d want 110 score=0",
                     {restart, running, game_over}, score);
        end
        // Apple on the frame_end cycle itself; ticks land on frames 7,13,17,21,24 as the period shrinks.
        for (int f = 1; f <= 24; f++) begin
            frame(2'b11, 2'b10);
            if (move_tick) ticks++;
        end
        n_vec++;
        if (score !== 8'd24 || ticks != 5) begin
            n_err++;
            $display("FAIL score24: score=%0d ticks=%0d want score=24 ticks=5", score, ticks);
        end
        frame(2'b11, 2'b11);
        n_vec++;
        if (move_tick !== 1'b0) begin
            n_err++;
            $display("FAIL period2_first: move_tick=%b want 0", move_tick);
        end
        frame(2'b11, 2'b11);
        n_vec++;
        if (move_tick !== 1'b1) begin
            n_err++;
            $display("FAIL period2_second: move_tick=%b want 1", move_tick);
        end
        for (int f = 0; f < 231; f++) frame(2'b10, 2'b11);
        n_vec++;
        if (score !== 8'd255) begin
            n_err++;
            $display("FAIL score255: got %0d want 255", score);
        end
        frame(2'b10, 2'b11);
        n_vec++;
        if ({score, grow, running} !== {8'd255, 2'b11}) begin
            n_err++;
            $display("FAIL score_saturate: score=%0d grow/run=%b want 255 11", score, {grow, running});
        end
    endtask

    task automatic test_reset_priority();
        coll_state = 2'b01;
        frame_end  = 1'b1;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        frame_end  = 1'b0;
        coll_state = 2'b11;
        n_vec++;
        if ({running, game_over, move_tick, grow, apple_respawn, restart, score} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_priority: got %b want all zero",
                     {running, game_over, move_tick, grow, apple_respawn, restart, score});
        end
        tick();
        n_vec++;
        if ({running, game_over, restart} !== 3'b000) begin
            n_err++;
            $display("FAIL post_reset_idle: run/over/restart=%b want 000", {running, game_over, restart});
        end
    endtask

    initial begin
        test_reset();
        test_move_rate();
        test_apple();
        test_hit_wins();
        test_speedup_saturate();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
